// File: rtl/line_sum_generator.sv
`default_nettype none
// ============================================================================
// Module      : line_sum_generator
// Description : Accumulates per-line sums of I, I*I and T[k]*I over a raster
//               frame, presenting registered results once per completed line.
//   Ports:
//     CLK                     - single clock, rising edge
//     reset                   - asynchronous, active-high reset
//     start                   - one-cycle frame start / abort request
//     pixel_valid             - pixel_in / template_pixel_in valid
//     pixel_ready             - block accepts a pixel (high while ACCUM)
//     pixel_in                - image pixel I (unsigned)
//     template_pixel_in[k]    - co-located template pixels T[k]
//     I_out_line_sum          - sum of I over last completed line
//     I_square_out_line_sum   - sum of I*I over last completed line
//     T_x_I_out_lines_sum[k]  - sum of T[k]*I over last completed line
//     line_sum_valid          - one-cycle pulse: new line sums present
//     frame_done              - one-cycle pulse with the final line's sums
// Revision    : 1.0 - initial release
// ============================================================================
module line_sum_generator #(
    parameter int LINE_SIZE     = 640,
    parameter int NUM_OF_LINES  = 480,
    parameter int PIXEL_SIZE    = 8,
    parameter int NUM_TEMPLATES = 4,
    localparam int SW           = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    input  logic [PIXEL_SIZE-1:0] pixel_in,
    input  logic [PIXEL_SIZE-1:0] template_pixel_in [NUM_TEMPLATES],
    output logic [SW-1:0]         I_out_line_sum,
    output logic [SW-1:0]         I_square_out_line_sum,
    output logic [SW-1:0]         T_x_I_out_lines_sum [NUM_TEMPLATES],
    output logic                  line_sum_valid,
    output logic                  frame_done
);

    localparam int PCW = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;
    localparam int LCW = (NUM_OF_LINES > 1) ? $clog2(NUM_OF_LINES) : 1;
    localparam int PW  = 2 * PIXEL_SIZE;
    localparam logic [PCW-1:0] PIX_LAST  = PCW'(LINE_SIZE - 1);
    localparam logic [LCW-1:0] LINE_LAST = LCW'(NUM_OF_LINES - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PCW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [LCW-1:0]   line_cnt_q, line_cnt_d;
    logic [SW-1:0]    i_sum_q, i_sum_d;
    logic [SW-1:0]    sq_sum_q, sq_sum_d;
    logic [SW-1:0]    txi_sum_q [NUM_TEMPLATES];
    logic [SW-1:0]    txi_sum_d [NUM_TEMPLATES];
    logic [SW-1:0]    i_out_q, i_out_d;
    logic [SW-1:0]    sq_out_q, sq_out_d;
    logic [SW-1:0]    txi_out_q [NUM_TEMPLATES];
    logic [SW-1:0]    txi_out_d [NUM_TEMPLATES];
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    // Partial sums including the current pixel
    logic [PW-1:0]    sq_prod;
    logic [SW-1:0]    i_acc;
    logic [SW-1:0]    sq_acc;
    logic [SW-1:0]    txi_acc [NUM_TEMPLATES];

    // Operands widened first so the product keeps its full 2*PIXEL_SIZE width
    assign sq_prod = {{PIXEL_SIZE{1'b0}}, pixel_in} * {{PIXEL_SIZE{1'b0}}, pixel_in};
    assign i_acc   = i_sum_q + SW'(pixel_in);
    assign sq_acc  = sq_sum_q + SW'(sq_prod);

    generate
        for (genvar k = 0; k < NUM_TEMPLATES; k++) begin : g_tmpl
            logic [PW-1:0] txi_prod;
            assign txi_prod   = {{PIXEL_SIZE{1'b0}}, template_pixel_in[k]} *
                                {{PIXEL_SIZE{1'b0}}, pixel_in};
            assign txi_acc[k] = txi_sum_q[k] + SW'(txi_prod);
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        i_sum_d    = i_sum_q;
        sq_sum_d   = sq_sum_q;
        txi_sum_d  = txi_sum_q;
        i_out_d    = i_out_q;
        sq_out_d   = sq_out_q;
        txi_out_d  = txi_out_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ACCUM;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                    i_sum_d    = '0;
                    sq_sum_d   = '0;
                    txi_sum_d  = '{default: '0};
                end
            end
            ACCUM: begin
                if (start) begin
                    // Abort: restart the frame, the partial line is dropped
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                    i_sum_d    = '0;
                    sq_sum_d   = '0;
                    txi_sum_d  = '{default: '0};
                end else if (pixel_valid) begin
                    if (pix_cnt_q == PIX_LAST) begin
                        // Last pixel: publish and restart with no bubble
                        i_out_d   = i_acc;
                        sq_out_d  = sq_acc;
                        txi_out_d = txi_acc;
                        valid_d   = 1'b1;
                        pix_cnt_d = '0;
                        i_sum_d   = '0;
                        sq_sum_d  = '0;
                        txi_sum_d = '{default: '0};
                        if (line_cnt_q == LINE_LAST) begin
                            done_d     = 1'b1;
                            state_d    = IDLE;
                            line_cnt_d = '0;
                        end else begin
                            line_cnt_d = line_cnt_q + 1'b1;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        i_sum_d   = i_acc;
                        sq_sum_d  = sq_acc;
                        txi_sum_d = txi_acc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            i_sum_q    <= '0;
            sq_sum_q   <= '0;
            txi_sum_q  <= '{default: '0};
            i_out_q    <= '0;
            sq_out_q   <= '0;
            txi_out_q  <= '{default: '0};
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            i_sum_q    <= i_sum_d;
            sq_sum_q   <= sq_sum_d;
            txi_sum_q  <= txi_sum_d;
            i_out_q    <= i_out_d;
            sq_out_q   <= sq_out_d;
            txi_out_q  <= txi_out_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign pixel_ready           = (state_q == ACCUM);
    assign I_out_line_sum        = i_out_q;
    assign I_square_out_line_sum = sq_out_q;
    assign T_x_I_out_lines_sum   = txi_out_q;
    assign line_sum_valid        = valid_q;
    assign frame_done            = done_q;

endmodule
`default_nettype wire

// File: tb/tb_line_sum_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_sum_generator
// Description : Self-checking bench for line_sum_generator (LINE_SIZE=4,
//               NUM_OF_LINES=2, PIXEL_SIZE=8, NUM_TEMPLATES=2, SW=18).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_sum_generator;

    localparam int LS = 4;
    localparam int NL = 2;
    localparam int PS = 8;
    localparam int NT = 2;
    localparam int SW = 18;

    logic          CLK = 1'b0;
    logic          reset;
    logic          start;
    logic          pixel_valid;
    logic          pixel_ready;
    logic [PS-1:0] pixel_in;
    logic [PS-1:0] tpix [NT];
    logic [SW-1:0] i_sum;
    logic [SW-1:0] sq_sum;
    logic [SW-1:0] txi [NT];
    logic          line_sum_valid;
    logic          frame_done;

    int checks   = 0;
    int failures = 0;

    line_sum_generator #(
        .LINE_SIZE    (LS),
        .NUM_OF_LINES (NL),
        .PIXEL_SIZE   (PS),
        .NUM_TEMPLATES(NT)
    ) dut (
        .CLK                  (CLK),
        .reset                (reset),
        .start                (start),
        .pixel_valid          (pixel_valid),
        .pixel_ready          (pixel_ready),
        .pixel_in             (pixel_in),
        .template_pixel_in    (tpix),
        .I_out_line_sum       (i_sum),
        .I_square_out_line_sum(sq_sum),
        .T_x_I_out_lines_sum  (txi),
        .line_sum_valid       (line_sum_valid),
        .frame_done           (frame_done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [0:3][7:0] i;
        logic [0:3][7:0] t0;
        logic [0:3][7:0] t1;
        logic [17:0]     e_i;
        logic [17:0]     e_sq;
        logic [17:0]     e_t0;
        logic [17:0]     e_t1;
    } vec_t;

    localparam int NV = 5;
    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic check_sums(input string tag, input logic [17:0] ei, input logic [17:0] esq,
                              input logic [17:0] et0, input logic [17:0] et1);
        check({tag, ".I"},   32'(i_sum),  32'(ei));
        check({tag, ".I2"},  32'(sq_sum), 32'(esq));
        check({tag, ".T0I"}, 32'(txi[0]), 32'(et0));
        check({tag, ".T1I"}, 32'(txi[1]), 32'(et1));
    endtask

    // Advance one clock, then sample 1 time unit after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        start       = 1'b0;
        pixel_valid = 1'b0;
        pixel_in    = '0;
        tpix[0]     = '0;
        tpix[1]     = '0;
    endtask

    // Start request with a junk pixel presented alongside (must be ignored)
    task automatic do_start();
        start       = 1'b1;
        pixel_valid = 1'b1;
        pixel_in    = 8'd200;
        tpix[0]     = 8'd200;
        tpix[1]     = 8'd200;
        tick();
        idle_inputs();
    endtask

    task automatic send_pixel(input logic [7:0] p, input logic [7:0] a, input logic [7:0] b);
        pixel_valid = 1'b1;
        pixel_in    = p;
        tpix[0]     = a;
        tpix[1]     = b;
        tick();
        idle_inputs();
    endtask

    // Sends a 4-pixel line; checks no pulse before the last pixel
    task automatic send_line(input string tag, input logic [0:3][7:0] i,
                             input logic [0:3][7:0] t0, input logic [0:3][7:0] t1);
        for (int p = 0; p < LS; p++) begin
            send_pixel(i[p], t0[p], t1[p]);
            if (p < LS - 1) check({tag, ".early_valid"}, 32'(line_sum_valid), 32'd0);
        end
    endtask

    initial begin
        // I, T0, T1 per pixel and hand-computed sums
        vec[0].i = {8'd1, 8'd2, 8'd3, 8'd4};
        vec[0].t0 = {8'd2, 8'd2, 8'd2, 8'd2};
        vec[0].t1 = {8'd255, 8'd255, 8'd255, 8'd255};
        vec[0].e_i = 18'd10; vec[0].e_sq = 18'd30; vec[0].e_t0 = 18'd20; vec[0].e_t1 = 18'd2550;

        vec[1].i = {8'd255, 8'd255, 8'd255, 8'd255};
        vec[1].t0 = {8'd255, 8'd255, 8'd255, 8'd255};
        vec[1].t1 = {8'd255, 8'd255, 8'd255, 8'd255};
        vec[1].e_i = 18'd1020; vec[1].e_sq = 18'd260100; vec[1].e_t0 = 18'd260100; vec[1].e_t1 = 18'd260100;

        vec[2].i = {8'd0, 8'd0, 8'd0, 8'd0};
        vec[2].t0 = {8'd7, 8'd7, 8'd7, 8'd7};
        vec[2].t1 = {8'd9, 8'd9, 8'd9, 8'd9};
        vec[2].e_i = 18'd0; vec[2].e_sq = 18'd0; vec[2].e_t0 = 18'd0; vec[2].e_t1 = 18'd0;

        vec[3].i = {8'd10, 8'd20, 8'd30, 8'd40};
        vec[3].t0 = {8'd1, 8'd1, 8'd1, 8'd1};
        vec[3].t1 = {8'd0, 8'd0, 8'd0, 8'd0};
        vec[3].e_i = 18'd100; vec[3].e_sq = 18'd3000; vec[3].e_t0 = 18'd100; vec[3].e_t1 = 18'd0;

        vec[4].i = {8'd5, 8'd6, 8'd7, 8'd8};
        vec[4].t0 = {8'd1, 8'd2, 8'd3, 8'd4};
        vec[4].t1 = {8'd8, 8'd7, 8'd6, 8'd5};
        vec[4].e_i = 18'd26; vec[4].e_sq = 18'd174; vec[4].e_t0 = 18'd70; vec[4].e_t1 = 18'd164;

        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("rst.ready", 32'(pixel_ready), 32'd0);
        check("rst.valid", 32'(line_sum_valid), 32'd0);
        check("rst.done",  32'(frame_done), 32'd0);
        check_sums("rst", 18'd0, 18'd0, 18'd0, 18'd0);
        reset = 1'b0;

        // No acceptance before start
        for (int p = 0; p < LS; p++) send_pixel(8'd9, 8'd9, 8'd9);
        check("nostart.ready", 32'(pixel_ready), 32'd0);
        check("nostart.valid", 32'(line_sum_valid), 32'd0);
        check_sums("nostart", 18'd0, 18'd0, 18'd0, 18'd0);

        // Table: each vector is the first line of a fresh frame
        for (int v = 0; v < NV; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            do_start();
            check({tag, ".ready"}, 32'(pixel_ready), 32'd1);
            send_line(tag, vec[v].i, vec[v].t0, vec[v].t1);
            check({tag, ".valid"}, 32'(line_sum_valid), 32'd1);
            check({tag, ".done"},  32'(frame_done), 32'd0);
            check_sums(tag, vec[v].e_i, vec[v].e_sq, vec[v].e_t0, vec[v].e_t1);
            tick();
            check({tag, ".valid_drop"}, 32'(line_sum_valid), 32'd0);
            check({tag, ".hold_I"}, 32'(i_sum), 32'(vec[v].e_i));
        end

        // Full frame back-to-back: pixels 1..8, T0=1, T1=2
        do_start();
        for (int p = 1; p <= 8; p++) begin
            send_pixel(8'(p), 8'd1, 8'd2);
            if (p == 4) begin
                check("frame.l1_valid", 32'(line_sum_valid), 32'd1);
                check("frame.l1_done",  32'(frame_done), 32'd0);
                check("frame.l1_ready", 32'(pixel_ready), 32'd1);
                check_sums("frame.l1", 18'd10, 18'd30, 18'd10, 18'd20);
            end else if (p == 8) begin
                check("frame.l2_valid", 32'(line_sum_valid), 32'd1);
                check("frame.l2_done",  32'(frame_done), 32'd1);
                check("frame.l2_ready", 32'(pixel_ready), 32'd0);
                check_sums("frame.l2", 18'd26, 18'd174, 18'd26, 18'd52);
            end else begin
                check("frame.mid_valid", 32'(line_sum_valid), 32'd0);
            end
        end
        // pixel_valid while IDLE: nothing changes
        for (int p = 0; p < 5; p++) begin
            send_pixel(8'd99, 8'd99, 8'd99);
            check("idle.valid", 32'(line_sum_valid), 32'd0);
            check("idle.done",  32'(frame_done), 32'd0);
            check("idle.ready", 32'(pixel_ready), 32'd0);
        end
        check_sums("idle", 18'd26, 18'd174, 18'd26, 18'd52);

        // Stall: vector 0 with gaps carrying junk on the data bus
        do_start();
        for (int p = 0; p < LS; p++) begin
            pixel_valid = 1'b0;
            pixel_in    = 8'd77;
            tpix[0]     = 8'd77;
            tpix[1]     = 8'd77;
            tick();
            tick();
            check("stall.gap_valid", 32'(line_sum_valid), 32'd0);
            send_pixel(vec[0].i[p], vec[0].t0[p], vec[0].t1[p]);
        end
        check("stall.valid", 32'(line_sum_valid), 32'd1);
        check_sums("stall", 18'd10, 18'd30, 18'd20, 18'd2550);

        // Abort: 2 pixels, start (with valid junk), then 4 ones
        do_start();
        send_pixel(8'd9, 8'd3, 8'd3);
        send_pixel(8'd9, 8'd3, 8'd3);
        do_start();
        check("abort.ready", 32'(pixel_ready), 32'd1);
        for (int p = 0; p < LS; p++) begin
            send_pixel(8'd1, 8'd1, 8'd1);
            if (p < LS - 1) check("abort.partial_valid", 32'(line_sum_valid), 32'd0);
        end
        check("abort.valid", 32'(line_sum_valid), 32'd1);
        check_sums("abort", 18'd4, 18'd4, 18'd4, 18'd4);

        // Async reset after 3 pixels of line 2
        do_start();
        send_line("rstmid.l1", vec[0].i, vec[0].t0, vec[0].t1);
        check("rstmid.l1_valid", 32'(line_sum_valid), 32'd1);
        for (int p = 0; p < 3; p++) send_pixel(8'd50, 8'd50, 8'd50);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid.ready", 32'(pixel_ready), 32'd0);
        check("rstmid.valid", 32'(line_sum_valid), 32'd0);
        check("rstmid.done",  32'(frame_done), 32'd0);
        check_sums("rstmid", 18'd0, 18'd0, 18'd0, 18'd0);
        tick();
        reset = 1'b0;
        tick();
        check("rstmid.post_ready", 32'(pixel_ready), 32'd0);
        do_start();
        send_line("rstmid.again", vec[0].i, vec[0].t0, vec[0].t1);
        check("rstmid.again_valid", 32'(line_sum_valid), 32'd1);
        check("rstmid.again_done",  32'(frame_done), 32'd0);
        check_sums("rstmid.again", 18'd10, 18'd30, 18'd20, 18'd2550);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
